// File: rtl/uart2bus_pkg.sv
// Shared definitions for the UART-to-bus command parser:
// command and acknowledge codes, FSM state encoding and the length decode helper.
package uart2bus_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] ACK_CODE  = 8'h5A;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ADDR_H   = 4'd1,
    ADDR_L   = 4'd2,
    LEN      = 4'd3,
    WR_DATA  = 4'd4,
    WR_BUS   = 4'd5,
    RD_BUS   = 4'd6,
    RD_CAP   = 4'd7,
    TX_START = 4'd8,
    TX_GUARD = 4'd9,
    TX_WAIT  = 4'd10
  } parserStateT;

  // A length byte of zero stands for a full 256-byte burst.
  function automatic logic [8:0] lenToCount(input logic [7:0] len);
    return (len == 8'h00) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer: counts enabled idle cycles and flags expiry once TIMEOUT
// cycles pass without a clear.
module uart_gap_timer #(
  parameter int TIMEOUT = 250000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] gapCount;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gapCount <= '0;
    end else if (clear || !enable) begin
      gapCount <= '0;
    end else if (!expired) begin
      gapCount <= gapCount + TW'(1);
    end
  end

  assign expired = enable && (gapCount == TW'(TIMEOUT));

endmodule

// File: rtl/uart_cmd_parser.sv
// UART command parser: decodes write/read frames from the receiver, drives the
// internal bus handshake and returns read data or a write acknowledge to the transmitter.
module uart_cmd_parser
  import uart2bus_pkg::*;
#(
  parameter int AW      = 16,
  parameter int TIMEOUT = 250000
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          new_rx_data,
  output logic [7:0]    tx_data,
  output logic          new_tx_data,
  input  logic          tx_busy,
  output logic [AW-1:0] int_address,
  output logic [7:0]    int_wr_data,
  output logic          int_write,
  output logic          int_read,
  input  logic [7:0]    int_rd_data,
  output logic          int_req,
  input  logic          int_gnt
);

  parserStateT state;
  parserStateT nextState;

  logic       isRead;
  logic [7:0] addrHigh;
  logic [8:0] count;

  logic issueWrite;
  logic issueRead;
  logic issueTx;
  logic captureRd;
  logic reqNext;
  logic timerEnable;
  logic timerExpired;

  uart_gap_timer #(.TIMEOUT(TIMEOUT)) gapTimer (
    .clock   (clock),
    .reset   (reset),
    .clear   (new_rx_data),
    .enable  (timerEnable),
    .expired (timerExpired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // NOTE: every always_comb assigns its outputs a default first, so no path
  // leaves a variable holding its old value and no latch is inferred.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:
        if (new_rx_data && (rx_data == CMD_WRITE || rx_data == CMD_READ)) nextState = ADDR_H;
      ADDR_H:
        if (new_rx_data)       nextState = ADDR_L;
        else if (timerExpired) nextState = IDLE;
      ADDR_L:
        if (new_rx_data)       nextState = LEN;
        else if (timerExpired) nextState = IDLE;
      LEN:
        if (new_rx_data)       nextState = isRead ? RD_BUS : WR_DATA;
        else if (timerExpired) nextState = IDLE;
      WR_DATA:
        if (new_rx_data)       nextState = WR_BUS;
        else if (timerExpired) nextState = IDLE;
      WR_BUS:
        if (int_gnt) nextState = (count == 9'd1) ? TX_START : WR_DATA;
      RD_BUS:
        if (int_gnt) nextState = RD_CAP;
      // RD_CAP spans the strobe cycle plus the cycle the read data is valid.
      RD_CAP:
        if (!int_read) nextState = TX_START;
      TX_START:
        if (!tx_busy) nextState = TX_GUARD;
      TX_GUARD:
        nextState = TX_WAIT;
      TX_WAIT:
        if (!tx_busy) nextState = (isRead && count != 9'd0) ? RD_BUS : IDLE;
      default:
        nextState = IDLE;
    endcase
  end

  always_comb begin
    issueWrite  = 1'b0;
    issueRead   = 1'b0;
    issueTx     = 1'b0;
    captureRd   = 1'b0;
    timerEnable = 1'b0;
    case (state)
      ADDR_H, ADDR_L, LEN, WR_DATA: timerEnable = 1'b1;
      WR_BUS:   issueWrite = int_gnt;
      RD_BUS:   issueRead  = int_gnt;
      RD_CAP:   captureRd  = !int_read;
      TX_START: issueTx    = !tx_busy;
      default:  ;
    endcase
    // Request stays up through the strobe cycle and drops right after it.
    reqNext = (nextState == WR_BUS) || (nextState == RD_BUS) || issueWrite || issueRead;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      isRead      <= 1'b0;
      addrHigh    <= '0;
      count       <= '0;
      int_address <= '0;
      int_wr_data <= '0;
      int_write   <= 1'b0;
      int_read    <= 1'b0;
      int_req     <= 1'b0;
      tx_data     <= '0;
      new_tx_data <= 1'b0;
    end else begin
      int_write   <= issueWrite;
      int_read    <= issueRead;
      int_req     <= reqNext;
      new_tx_data <= issueTx;

      if (state == IDLE && nextState == ADDR_H) isRead <= (rx_data == CMD_READ);
      if (state == ADDR_H && new_rx_data) addrHigh <= rx_data;

      // Address advances only after the strobe cycle so the bus sees it stable.
      if (state == ADDR_L && new_rx_data)  int_address <= AW'({addrHigh, rx_data});
      else if (int_write || int_read)      int_address <= int_address + AW'(1);

      if (state == LEN && new_rx_data)     count <= lenToCount(rx_data);
      else if (issueWrite || issueRead)    count <= count - 9'd1;

      if (state == WR_DATA && new_rx_data) int_wr_data <= rx_data;

      if (captureRd)                          tx_data <= int_rd_data;
      else if (issueWrite && count == 9'd1)   tx_data <= ACK_CODE;
    end
  end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter AW, default 16, internal bus address width.
REQ-002 SHALL have parameter TIMEOUT, default 250000, idle clock cycles allowed between received command bytes before abort.
REQ-003 SHALL have port clock  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port rx_data  in  8  byte received from the UART.
REQ-006 SHALL have port new_rx_data  in  1  one-cycle strobe; rx_data valid.
REQ-007 SHALL have port tx_data  out  8  byte to transmit.
REQ-008 SHALL have port new_tx_data  out  1  one-cycle transmit start strobe.
REQ-009 SHALL have port tx_busy  in  1  transmitter busy.
REQ-010 SHALL have port int_address  out  AW  bus address.
REQ-011 SHALL have port int_wr_data  out  8  bus write data.
REQ-012 SHALL have port int_write  out  1  one-cycle write strobe.
REQ-013 SHALL have port int_read  out  1  one-cycle read strobe.
REQ-014 SHALL have port int_rd_data  in  8  read data, valid exactly one cycle after int_read.
REQ-015 SHALL have port int_req  out  1  bus request, held high for the whole transfer.
REQ-016 SHALL have port int_gnt  in  1  bus grant.

Function
REQ-017 Frame: CMD, ADDR_H, ADDR_L, LEN, then LEN data bytes for writes only; CMD 0x01 = write, 0x02 = read; LEN 0 means 256.
REQ-018 Bytes are sampled only in cycles with new_rx_data=1; a CMD byte other than 0x01/0x02 is discarded and the FSM stays in IDLE.
REQ-019 FSM states: IDLE, ADDR_H, ADDR_L, LEN, WR_DATA, WR_BUS, RD_BUS, RD_CAP, TX_START, TX_GUARD, TX_WAIT.
REQ-020 Write path: each data byte in WR_DATA latches into int_wr_data, then goes to WR_BUS. Assert int_req and wait for int_gnt. Pulse int_write for 1 cycle. Increment address, decrement count. Return to WR_DATA, or after the last byte send ack 0x5A via the TX states.
REQ-021 Read path: after LEN, go to RD_BUS. Assert int_req and wait for int_gnt. Pulse int_read. In RD_CAP, capture int_rd_data into tx_data. Send it via the TX states. Increment address, decrement count. Repeat, then return to IDLE after the last byte.
REQ-022 TX handshake: TX_START waits for tx_busy=0, then pulses new_tx_data for 1 cycle. TX_GUARD ignores tx_busy for exactly one cycle. TX_WAIT waits for tx_busy=0 before continuing.
REQ-023 int_req SHALL fall in the cycle after the final int_write/int_read strobe; int_write and int_read are never high together.
REQ-024 Address increments modulo 2^AW; wrap from all-ones to 0 is legal and silent.
REQ-025 Count register is 9 bits; LEN 0 loads 256.
REQ-026 Inter-byte timer: counts in ADDR_H, ADDR_L, LEN and WR_DATA; clears on new_rx_data; reaching TIMEOUT forces IDLE without a bus strobe or ack.
REQ-027 new_rx_data arriving in any bus or TX state is dropped, with no effect on the FSM.
REQ-028 tx_data holds its value until the next capture.

Reset
REQ-029 Reset forces IDLE, count=0, timer=0 and all outputs to 0 immediately, including mid-transfer; no partial strobe completes.
REQ-030 After reset release, the first byte accepted is treated as CMD.

Structure
REQ-031 Command codes (0x01, 0x02), ack code (0x5A) and the FSM state encoding SHALL live in a shared package uart2bus_pkg.
REQ-032 The inter-byte timer SHALL be a sub-module uart_gap_timer (clear, enable, expired).

Verification
REQ-033 Write: send 01 12 34 02 AA BB with gnt tied high -> int_write at 0x1234=AA and 0x1235=BB, then tx_data=5A with one new_tx_data pulse.
REQ-034 Read: send 02 00 10 03; bus returns 11,22,33 -> three reads at 0x0010..0x0012; TX bytes 11,22,33, each started only after tx_busy fell.
REQ-035 Wrap: with AW=16, send 02 FF FF 02 -> reads at 0xFFFF then 0x0000.
REQ-036 Timeout: with TIMEOUT=100, send 01 12 then idle 100 cycles -> IDLE; a following 02 00 00 01 executes a read at 0x0000.
REQ-037 Grant stall: hold int_gnt=0 for 50 cycles during a write -> int_req high with no strobe; strobe comes 1 cycle after gnt rises.
REQ-038 Reset asserted in RD_BUS while waiting for gnt -> all outputs 0 asynchronously; no read strobe after release.
